// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-RAM arbiter: S-100 bus constants,
// port-owner and arbiter-state encodings.
package mem_arbiter_pkg;

    localparam int S100_DATA_WIDTH = 8;
    localparam int MAIN_RAM_WORDS  = 8192;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DMA_BURST = 2'd1,
        ST_CPU_FORCE = 2'd2
    } arb_state_t;

    function automatic logic cpu_pending(input logic rd, input logic we);
        return rd | we;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, DMA and shared-RAM signals of the arbiter. The arbiter uses the slave
// modport; requesters and the RAM model use the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 13
);
    import mem_arbiter_pkg::*;

    // Requests are levels held until accepted: a CPU access completes in the
    // cycle cpu_ready=1, a DMA access in the cycle dma_gnt=1. Read data returns
    // one cycle after mem_rd (cpu_rdata captured one edge later, dma_rvalid strobe).
    logic [ADDR_WIDTH-1:0]      cpu_addr;
    logic [S100_DATA_WIDTH-1:0] cpu_wdata;
    logic                       cpu_rd;
    logic                       cpu_we;
    logic                       cpu_ready;
    logic [S100_DATA_WIDTH-1:0] cpu_rdata;

    logic                       dma_req;
    logic                       dma_we;
    logic [ADDR_WIDTH-1:0]      dma_addr;
    logic [S100_DATA_WIDTH-1:0] dma_wdata;
    logic                       dma_gnt;
    logic                       dma_rvalid;
    logic [S100_DATA_WIDTH-1:0] dma_rdata;

    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [S100_DATA_WIDTH-1:0] mem_wdata;
    logic                       mem_rd;
    logic                       mem_we;
    logic [S100_DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_we,
        output cpu_ready, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_we,
        input  cpu_ready, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_burst_counter.sv
// Counts contended DMA grants; saturates at MAX_BURST and flags it so the
// arbiter can hand one slot to the CPU.
module burst_counter #(
    parameter int MAX_BURST = 16,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          at_max
);

    assign at_max = (count == CW'(MAX_BURST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_max) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-RAM arbiter between the CPU and a DMA engine. DMA has
// priority but yields one slot to a waiting CPU after MAX_BURST grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(MAIN_RAM_WORDS),
    parameter int MAX_BURST  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    mem_arbiter_if.slave                   bus,
    output arb_state_t                     dbg_state,
    output logic [$clog2(MAX_BURST+1)-1:0] dbg_burst_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t                 state;
    arb_state_t                 next_state;
    owner_t                     owner;
    owner_t                     ret_owner;
    logic                       cpu_pend;
    logic                       burst_clear;
    logic                       burst_en;
    logic                       burst_at_max;
    logic [BW-1:0]              burst_cnt;
    logic [ADDR_WIDTH-1:0]      addr_c;
    logic [S100_DATA_WIDTH-1:0] wdata_c;
    logic                       rd_c;
    logic                       we_c;
    logic [S100_DATA_WIDTH-1:0] cpu_rdata_q;

    assign cpu_pend = cpu_pending(bus.cpu_rd, bus.cpu_we);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // CPU_FORCE arbitrates like IDLE; it only marks that the CPU just had its slot.
    always_comb begin
        next_state = state;
        owner      = OWN_NONE;
        unique case (state)
            ST_IDLE, ST_CPU_FORCE: begin
                if (bus.dma_req) begin
                    owner      = OWN_DMA;
                    next_state = ST_DMA_BURST;
                end else begin
                    next_state = ST_IDLE;
                    if (cpu_pend) owner = OWN_CPU;
                end
            end
            ST_DMA_BURST: begin
                if (bus.dma_req && !(cpu_pend && burst_at_max)) begin
                    owner = OWN_DMA;
                end else if (cpu_pend) begin
                    owner      = OWN_CPU;
                    next_state = ST_CPU_FORCE;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (!reset) begin
            owner      = OWN_NONE;
            next_state = ST_IDLE;
        end
    end

    assign burst_clear = (next_state != ST_DMA_BURST);
    assign burst_en    = (owner == OWN_DMA) && cpu_pend;

    burst_counter #(
        .MAX_BURST(MAX_BURST)
    ) u_burst_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (burst_clear),
        .enable (burst_en),
        .count  (burst_cnt),
        .at_max (burst_at_max)
    );

    // Write beats read when the CPU asserts both.
    always_comb begin
        addr_c  = '0;
        wdata_c = '0;
        rd_c    = 1'b0;
        we_c    = 1'b0;
        unique case (owner)
            OWN_CPU: begin
                addr_c  = bus.cpu_addr;
                wdata_c = bus.cpu_wdata;
                we_c    = bus.cpu_we;
                rd_c    = bus.cpu_rd & ~bus.cpu_we;
            end
            OWN_DMA: begin
                addr_c  = bus.dma_addr;
                wdata_c = bus.dma_wdata;
                we_c    = bus.dma_we;
                rd_c    = ~bus.dma_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_owner   <= OWN_NONE;
            cpu_rdata_q <= '0;
        end else begin
            ret_owner <= rd_c ? owner : OWN_NONE;
            if (ret_owner == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_addr   = addr_c;
    assign bus.mem_wdata  = wdata_c;
    assign bus.mem_rd     = rd_c;
    assign bus.mem_we     = we_c;
    assign bus.cpu_ready  = (owner == OWN_CPU);
    assign bus.dma_gnt    = (owner == OWN_DMA);
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rvalid = (ret_owner == OWN_DMA);
    assign bus.dma_rdata  = (ret_owner == OWN_DMA) ? bus.mem_rdata : '0;

    assign dbg_state     = state;
    assign dbg_burst_cnt = burst_cnt;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, memory word-address width (8 KB main RAM).
REQ-002 Parameter MAX_BURST, default 16, maximum consecutive DMA grants while CPU is pending.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cpu_addr  input  ADDR_WIDTH  CPU word address.
REQ-006 cpu_wdata  input  8  CPU write data.
REQ-007 cpu_rd / cpu_we  input  1 each  CPU read / write request, level, held until cpu_ready=1.
REQ-008 cpu_ready  output  1  CPU access granted this cycle; CPU stalls (ce held) while 0.
REQ-009 cpu_rdata  output  8  registered CPU read data.
REQ-010 dma_req / dma_we  input  1 each  DMA access request; dma_we=1 write, 0 read.
REQ-011 dma_addr / dma_wdata  input  ADDR_WIDTH / 8  DMA address / write data.
REQ-012 dma_gnt  output  1  DMA access accepted this cycle.
REQ-013 dma_rvalid / dma_rdata  output  1 / 8  DMA read data valid strobe / data.
REQ-014 mem_addr / mem_wdata  output  ADDR_WIDTH / 8  shared synchronous RAM port.
REQ-015 mem_rd / mem_we  output  1 each  RAM read / write enable.
REQ-016 mem_rdata  input  8  RAM read data, valid one cycle after mem_rd.

Function
REQ-017 Exactly one owner per cycle: NONE, CPU or DMA; mem_* SHALL be muxed combinationally from the owner; NONE drives mem_rd=mem_we=0, mem_addr=0, mem_wdata=0.
REQ-018 cpu_pend = cpu_rd|cpu_we; if both asserted, write SHALL win and no read is issued.
REQ-019 FSM states IDLE, DMA_BURST, CPU_FORCE; reset state IDLE.
REQ-020 IDLE: dma_req -> owner DMA, go DMA_BURST, burst_cnt=1; else cpu_pend -> owner CPU; else NONE.
REQ-021 DMA_BURST: dma_req and not (cpu_pend and burst_cnt==MAX_BURST) -> owner DMA, burst_cnt+1 (saturating at MAX_BURST); else if cpu_pend -> owner CPU, go CPU_FORCE; else owner NONE, go IDLE.
REQ-022 burst_cnt SHALL increment only on cycles with owner DMA and cpu_pend=1; cleared on entering IDLE or CPU_FORCE.
REQ-023 CPU_FORCE: exactly one cycle; then return to IDLE (DMA re-arbitrated next cycle).
REQ-024 cpu_ready = (owner==CPU); dma_gnt = (owner==DMA); both combinational, never both 1.
REQ-025 Read-return owner SHALL be registered; the cycle after a CPU read grant, cpu_rdata <= mem_rdata; cpu_rdata holds otherwise.
REQ-026 The cycle after a DMA read grant, dma_rvalid=1 (registered) and dma_rdata=mem_rdata; dma_rvalid=0 otherwise; back-to-back DMA reads yield one strobe per grant.
REQ-027 Writes: no return strobe; write takes effect at the granting clock edge.
REQ-028 Latency: uncontended CPU read data on cpu_rdata two edges after request (grant edge + capture edge); DMA read data with dma_rvalid one cycle after dma_gnt.
REQ-029 A CPU pending while DMA holds the port SHALL be granted within MAX_BURST+1 cycles.
REQ-030 Request deasserted in the same cycle as grant is still serviced; dropped requests before grant are not serviced.

Reset
REQ-031 While reset=0: state IDLE, burst_cnt=0, cpu_rdata=0, dma_rvalid=0, dma_rdata pipeline cleared, read-return owner NONE, cpu_ready=dma_gnt=mem_rd=mem_we=0.
REQ-032 Reset asserted mid-burst or with a read in flight SHALL discard the pending return; no dma_rvalid after release.
REQ-033 First arbitration SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-034 Owner encoding (NONE/CPU/DMA) and FSM state encoding SHALL live in a shared package with the S-100 bus constants.
REQ-035 Burst counter SHALL be a sub-module burst_counter (clear, enable, saturate at MAX_BURST, at_max flag).
REQ-036 No RAM instance inside; mem_arbiter sits between cpu/ce logic and ram_memory.

Verification
REQ-037 CPU read 0x0100 alone, RAM[0x0100]=0xA5 -> cpu_ready=1 on cycle 0, cpu_rdata=0xA5 after cycle 1, dma_gnt=0 throughout.
REQ-038 dma_req and cpu_rd asserted together from IDLE -> DMA granted first, CPU granted next cycle (cpu_pend, burst_cnt irrelevant after DMA drops).
REQ-039 dma_req held 40 cycles with cpu_we pending, MAX_BURST=16 -> 16 DMA grants, 1 CPU grant, 16 DMA grants, pattern repeats; cpu_ready asserted on cycles 16 and 33.
REQ-040 DMA reads 0x0000..0x0003 back-to-back, RAM=0x11,0x22,0x33,0x44 -> dma_rvalid high 4 consecutive cycles with those values, cpu_rdata unchanged.
REQ-041 reset pulled low the cycle after a DMA read grant -> dma_rvalid stays 0, all outputs 0, FSM IDLE after release.
REQ-042 cpu_rd and cpu_we both asserted, addr 0x0010, wdata 0x5A -> mem_we=1, mem_rd=0; subsequent read returns 0x5A.
